// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC: mode codes, FSM states, gain and arctangent tables.
package cordic_pkg;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_ITER, ST_POST} cordic_state_t;

    // K = 0.6072529350 in Q0.32
    localparam logic [31:0] K_Q32 = 32'd2608131496;

    // round(atan(2^-i) * 2^40 / 2pi)
    localparam logic [39:0] ATAN40 [40] = '{
        40'd137438953472, 40'd81134951838, 40'd42869480287, 40'd21761217566,
        40'd10922836750,  40'd5466743129,  40'd2734038620,  40'd1367102738,
        40'd683561799,    40'd341782203,   40'd170891265,   40'd85445653,
        40'd42722829,     40'd21361415,    40'd10680707,    40'd5340354,
        40'd2670177,      40'd1335088,     40'd667544,      40'd333772,
        40'd166886,       40'd83443,       40'd41722,       40'd20861,
        40'd10430,        40'd5215,        40'd2608,        40'd1304,
        40'd652,          40'd326,         40'd163,         40'd81,
        40'd41,           40'd20,          40'd10,          40'd5,
        40'd3,            40'd1,           40'd1,           40'd0
    };

    // round(AMP * K * 2^guard): the pre-compensated rotation start vector
    function automatic logic [63:0] k_scaled(input int out_w, input int guard);
        logic [63:0] amp;
        logic [63:0] prod;
        amp  = (64'd1 << (out_w - 1)) - 64'd1;
        prod = (amp * 64'(K_Q32)) << guard;
        return (prod + 64'h8000_0000) >> 32;
    endfunction

    function automatic logic [39:0] atan_entry(input int i, input int angle_w);
        logic [39:0] t;
        t = ATAN40[i];
        if (angle_w >= 40)
            return t;
        return (t + (40'd1 << (39 - angle_w))) >> (40 - angle_w);
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, one binary-angle entry per micro-rotation index.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int ANGLE_W = 32,
    parameter int ITERS   = 16,
    localparam int IW     = $clog2(ITERS)
) (
    input  logic [IW-1:0]      idx,
    output logic [ANGLE_W-1:0] atan_val
);

    logic [ANGLE_W-1:0] tab [ITERS];

    for (genvar g = 0; g < ITERS; g++) begin : g_tab
        assign tab[g] = ANGLE_W'(atan_entry(g, ANGLE_W));
    end

    always_comb begin
        atan_val = '0;
        if (int'(idx) < ITERS)
            atan_val = tab[idx];
    end

endmodule

// File: rtl/cordic_sincos_iter.sv
// Iterative CORDIC: one shared shift-add stage, rotation (sin/cos) or vectoring (mag/phase)
// with full-circle folding, rounding and symmetric saturation.
module cordic_sincos_iter
    import cordic_pkg::*;
#(
    parameter int OUT_W   = 16,
    parameter int ANGLE_W = 32,
    parameter int ITERS   = 16,
    parameter int GUARD   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      mode,
    input  logic [ANGLE_W-1:0]        angle_in,
    input  logic signed [OUT_W-1:0]   x_in,
    input  logic signed [OUT_W-1:0]   y_in,
    output logic                      busy,
    output logic signed [OUT_W-1:0]   sine_out,
    output logic signed [OUT_W-1:0]   cosine_out,
    output logic [ANGLE_W-1:0]        angle_out,
    output logic                      data_valid
);

    // Two headroom bits cover CORDIC gain on a full-scale diagonal vector
    localparam int XW = OUT_W + GUARD + 2;
    localparam int RW = XW + 1;
    localparam int IW = $clog2(ITERS);
    localparam int KS = 16;
    localparam int PW = XW + KS + 1;

    localparam logic signed [RW-1:0] AMP    = RW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [RW-1:0] HALF   = RW'(1 << (GUARD - 1));
    localparam logic signed [PW-1:0] PHALF  = PW'(64'd1 << (KS + GUARD - 1));
    localparam logic signed [XW-1:0] X0_ROT = XW'(k_scaled(OUT_W, GUARD));
    localparam logic [ANGLE_W-1:0]   PI     = {1'b1, {(ANGLE_W-1){1'b0}}};

    cordic_state_t             state;
    logic [IW-1:0]             iter;
    logic                      mode_r;
    logic                      negate_r;
    logic                      zero_r;
    logic [ANGLE_W-1:0]        angle_r;
    logic signed [OUT_W-1:0]   xin_r;
    logic signed [OUT_W-1:0]   yin_r;
    logic signed [XW-1:0]      x_r;
    logic signed [XW-1:0]      y_r;
    logic [ANGLE_W-1:0]        z_r;

    logic [ANGLE_W-1:0]        atan_val;
    logic signed [XW-1:0]      x_sh, y_sh, x_nxt, y_nxt;
    logic [ANGLE_W-1:0]        z_nxt;
    logic                      d_pos;
    logic                      rot_fold, vec_neg, rot_neg;
    logic signed [XW-1:0]      xin_ext, yin_ext;
    logic signed [RW-1:0]      x_pn, y_pn, x_rnd, y_rnd, mag_rnd;
    logic signed [PW-1:0]      x_k, k_prod;

    cordic_atan_rom #(.ANGLE_W(ANGLE_W), .ITERS(ITERS)) u_rom (
        .idx      (iter),
        .atan_val (atan_val)
    );

    assign x_sh  = x_r >>> iter;
    assign y_sh  = y_r >>> iter;
    assign d_pos = (mode_r == MODE_VEC) ? y_r[XW-1] : ~z_r[ANGLE_W-1];
    assign x_nxt = d_pos ? x_r - y_sh : x_r + y_sh;
    assign y_nxt = d_pos ? y_r + x_sh : y_r - x_sh;
    assign z_nxt = d_pos ? z_r - atan_val : z_r + atan_val;

    // Angles in the left half-plane are rotated by pi and the result negated
    assign rot_fold = angle_r[ANGLE_W-1] ^ angle_r[ANGLE_W-2];
    assign vec_neg  = xin_r[OUT_W-1];
    assign xin_ext  = {{(XW-OUT_W){xin_r[OUT_W-1]}}, xin_r} << GUARD;
    assign yin_ext  = {{(XW-OUT_W){yin_r[OUT_W-1]}}, yin_r} << GUARD;

    assign rot_neg = negate_r && (mode_r == MODE_ROT);
    assign x_pn    = rot_neg ? -{x_r[XW-1], x_r} : {x_r[XW-1], x_r};
    assign y_pn    = rot_neg ? -{y_r[XW-1], y_r} : {y_r[XW-1], y_r};
    assign x_rnd   = (x_pn + HALF) >>> GUARD;
    assign y_rnd   = (y_pn + HALF) >>> GUARD;

    // Magnitude * K as 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13 - 2^-14 + 2^-16, kept exact until rounding
    assign x_k     = {{(PW-XW){x_r[XW-1]}}, x_r};
    assign k_prod  = (x_k <<< 15) + (x_k <<< 13) - (x_k <<< 10) - (x_k <<< 7)
                   - (x_k <<< 3) - (x_k <<< 2) + x_k;
    assign mag_rnd = RW'((k_prod + PHALF) >>> (KS + GUARD));

    function automatic logic signed [OUT_W-1:0] sat(input logic signed [RW-1:0] v);
        if (v > AMP)
            return OUT_W'(AMP);
        else if (v < -AMP)
            return OUT_W'(-AMP);
        return OUT_W'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            iter       <= '0;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            sine_out   <= '0;
            cosine_out <= '0;
            angle_out  <= '0;
            mode_r     <= MODE_ROT;
            negate_r   <= 1'b0;
            zero_r     <= 1'b0;
            angle_r    <= '0;
            xin_r      <= '0;
            yin_r      <= '0;
            x_r        <= '0;
            y_r        <= '0;
            z_r        <= '0;
        end else if (!enable) begin
            data_valid <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r  <= mode;
                        angle_r <= angle_in;
                        xin_r   <= x_in;
                        yin_r   <= y_in;
                        busy    <= 1'b1;
                        state   <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    iter <= '0;
                    if (mode_r == MODE_ROT) begin
                        x_r      <= X0_ROT;
                        y_r      <= '0;
                        z_r      <= rot_fold ? angle_r + PI : angle_r;
                        negate_r <= rot_fold;
                        zero_r   <= 1'b0;
                    end else begin
                        x_r      <= vec_neg ? -xin_ext : xin_ext;
                        y_r      <= vec_neg ? -yin_ext : yin_ext;
                        z_r      <= '0;
                        negate_r <= vec_neg;
                        zero_r   <= (xin_r == '0) && (yin_r == '0);
                    end
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    x_r <= x_nxt;
                    y_r <= y_nxt;
                    z_r <= z_nxt;
                    if (iter == IW'(ITERS - 1))
                        state <= ST_POST;
                    else
                        iter <= iter + IW'(1);
                end
                ST_POST: begin
                    sine_out <= sat(y_rnd);
                    if (mode_r == MODE_ROT) begin
                        cosine_out <= sat(x_rnd);
                        angle_out  <= z_r;
                    end else begin
                        cosine_out <= sat(mag_rnd);
                        angle_out  <= zero_r ? '0 : (negate_r ? z_r + PI : z_r);
                    end
                    data_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// Directed, table-driven bench for cordic_sincos_iter plus handshake and reset sequences.
module tb_cordic_sincos_iter;

    logic               clk = 1'b0;
    logic               rst_n, enable, start, mode;
    logic [31:0]        angle_in, angle_out;
    logic signed [15:0] x_in, y_in, sine_out, cosine_out;
    logic               busy, data_valid;

    int checks   = 0;
    int failures = 0;
    int neg_hits = 0;
    logic signed [15:0] cap_sin, cap_cos;
    logic [31:0]        cap_ang;

    typedef struct {
        logic               m;
        logic [31:0]        ang;
        logic signed [15:0] xi;
        logic signed [15:0] yi;
        int                 e_sin;
        int                 e_cos;
        logic [31:0]        e_ang;
        int                 ang_tol;
        bit                 chk_ang;
    } vec_t;

    vec_t vecs [11];

    cordic_sincos_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .start      (start),
        .mode       (mode),
        .angle_in   (angle_in),
        .x_in       (x_in),
        .y_in       (y_in),
        .busy       (busy),
        .sine_out   (sine_out),
        .cosine_out (cosine_out),
        .angle_out  (angle_out),
        .data_valid (data_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (sine_out == -16'sd32768 || cosine_out == -16'sd32768)
            neg_hits++;
    endtask

    task automatic check_output(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act > exp + tol || act < exp - tol) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic check_angle(input string name, input logic [31:0] act, input logic [31:0] exp,
                               input int tol);
        logic signed [31:0] diff;
        diff = act - exp;
        checks++;
        if (diff > tol || diff < -tol) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h +/- 0x%0h", name, act, exp, tol);
        end
    endtask

    // Launch one operation and watch a fixed 48-cycle window after acceptance
    task automatic apply_stimulus(input logic m, input logic [31:0] ang,
                                  input logic signed [15:0] xi, input logic signed [15:0] yi,
                                  input int pause_at, input int glitch_at,
                                  output int lat, output int ndv, output int nbusy);
        mode = m; angle_in = ang; x_in = xi; y_in = yi;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        lat = 0; ndv = 0;
        nbusy = busy ? 1 : 0;
        for (int n = 1; n <= 48; n++) begin
            start  = (n == glitch_at);
            if (n == glitch_at) angle_in = 32'h4000_0000;
            enable = !(pause_at > 0 && n >= pause_at && n < pause_at + 5);
            step();
            if (busy) nbusy++;
            if (data_valid) begin
                ndv++;
                if (lat == 0) begin
                    lat = n;
                    cap_sin = sine_out; cap_cos = cosine_out; cap_ang = angle_out;
                end
            end
        end
        start = 1'b0; enable = 1'b1;
    endtask

    initial begin
        int lat, ndv, nbusy, n;

        vecs[0]  = '{1'b0, 32'h0000_0000, 16'sd0, 16'sd0, 0, 32767, 32'h0, 0, 1'b0};
        vecs[1]  = '{1'b0, 32'h4000_0000, 16'sd0, 16'sd0, 32767, 0, 32'h0, 0, 1'b0};
        vecs[2]  = '{1'b0, 32'h8000_0000, 16'sd0, 16'sd0, 0, -32767, 32'h0, 0, 1'b0};
        vecs[3]  = '{1'b0, 32'hC000_0000, 16'sd0, 16'sd0, -32767, 0, 32'h0, 0, 1'b0};
        vecs[4]  = '{1'b0, 32'h2AAA_AAAA, 16'sd0, 16'sd0, 28377, 16384, 32'h0, 0, 1'b0};
        vecs[5]  = '{1'b0, 32'h871C_71C7, 16'sd0, 16'sd0, -5690, -32269, 32'h0, 0, 1'b0};
        vecs[6]  = '{1'b0, 32'h3555_5555, 16'sd0, 16'sd0, 31650, 8481, 32'h0, 0, 1'b0};
        vecs[7]  = '{1'b1, 32'h0, -16'sd16384, 16'sd16384, 0, 23170, 32'h6000_0000, 32'h10000, 1'b1};
        vecs[8]  = '{1'b1, 32'h0, 16'sd0, 16'sd0, 0, 0, 32'h0, 0, 1'b1};
        vecs[9]  = '{1'b1, 32'h0, 16'sd3000, 16'sd4000, 0, 5000, 32'd633866811, 32'h10000, 1'b1};
        vecs[10] = '{1'b1, 32'h0, -16'sd20000, -16'sd15000, 0, 25000, 32'd2587358661, 32'h10000, 1'b1};

        rst_n = 1'b0; enable = 1'b1; start = 1'b0; mode = 1'b0;
        angle_in = '0; x_in = '0; y_in = '0;
        cap_sin = '0; cap_cos = '0; cap_ang = '0;
        step(); step();
        check_output("reset_busy", int'(busy), 0, 0);
        check_output("reset_valid", int'(data_valid), 0, 0);
        check_output("reset_sin", int'(sine_out), 0, 0);
        check_output("reset_cos", int'(cosine_out), 0, 0);
        check_angle("reset_angle", angle_out, 32'h0, 0);
        rst_n = 1'b1;
        step();

        for (int k = 0; k < 11; k++) begin
            apply_stimulus(vecs[k].m, vecs[k].ang, vecs[k].xi, vecs[k].yi, 0, 0, lat, ndv, nbusy);
            check_output($sformatf("v%0d_latency", k), lat, 18, 0);
            check_output($sformatf("v%0d_pulses", k), ndv, 1, 0);
            check_output($sformatf("v%0d_busy", k), nbusy, 18, 0);
            check_output($sformatf("v%0d_sin", k), int'(cap_sin), vecs[k].e_sin, 3);
            check_output($sformatf("v%0d_cos", k), int'(cap_cos), vecs[k].e_cos, 3);
            if (vecs[k].chk_ang)
                check_angle($sformatf("v%0d_angle", k), cap_ang, vecs[k].e_ang, vecs[k].ang_tol);
        end

        // A start pulse while busy (with a different angle) must be ignored
        apply_stimulus(1'b0, 32'h0000_0000, 16'sd0, 16'sd0, 0, 5, lat, ndv, nbusy);
        check_output("ignore_start_pulses", ndv, 1, 0);
        check_output("ignore_start_sin", int'(cap_sin), 0, 3);
        check_output("ignore_start_cos", int'(cap_cos), 32767, 3);

        // Freezing the clock-enable mid-iteration stretches latency only
        apply_stimulus(1'b0, 32'h2AAA_AAAA, 16'sd0, 16'sd0, 5, 0, lat, ndv, nbusy);
        check_output("pause_latency", lat, 23, 0);
        check_output("pause_pulses", ndv, 1, 0);
        check_output("pause_sin", int'(cap_sin), 28377, 3);
        check_output("pause_cos", int'(cap_cos), 16384, 3);

        // Back-to-back: restart in the data_valid cycle
        mode = 1'b0; angle_in = 32'h0000_0000; start = 1'b1;
        step();
        start = 1'b0; n = 0;
        while (!data_valid && n < 40) begin step(); n++; end
        check_output("b2b_first_latency", n, 18, 0);
        angle_in = 32'h2AAA_AAAA; start = 1'b1;
        step();
        start = 1'b0; n = 0;
        while (!data_valid && n < 40) begin step(); n++; end
        check_output("b2b_second_latency", n, 18, 0);
        check_output("b2b_second_sin", int'(sine_out), 28377, 3);
        check_output("b2b_second_cos", int'(cosine_out), 16384, 3);
        step();

        // Reset mid-iteration discards the operation and clears outputs
        mode = 1'b0; angle_in = 32'h3555_5555; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        rst_n = 1'b0;
        step();
        check_output("midrst_busy", int'(busy), 0, 0);
        check_output("midrst_valid", int'(data_valid), 0, 0);
        check_output("midrst_sin", int'(sine_out), 0, 0);
        check_output("midrst_cos", int'(cosine_out), 0, 0);
        check_angle("midrst_angle", angle_out, 32'h0, 0);
        rst_n = 1'b1;
        ndv = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (data_valid) ndv++;
        end
        check_output("midrst_no_pulse", ndv, 0, 0);
        apply_stimulus(1'b0, 32'h3555_5555, 16'sd0, 16'sd0, 0, 0, lat, ndv, nbusy);
        check_output("postrst_latency", lat, 18, 0);
        check_output("postrst_sin", int'(cap_sin), 31650, 3);
        check_output("postrst_cos", int'(cap_cos), 8481, 3);

        check_output("never_minus_32768", neg_hits, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
